// File: rtl/axi_stream_pkg.sv
// Shared types and helpers for the AXI-Stream header insert/extract blocks.
// Keep masks here are MSB-aligned for payload and LSB-aligned for headers.
package axi_stream_pkg;

   localparam int DATA_WD      = 32;
   localparam int DATA_BYTE_WD = DATA_WD / 8;
   localparam int CNT_WD       = $clog2(DATA_BYTE_WD + 1);

   typedef enum logic [1:0] {
      SOP,
      BODY,
      FLUSH
   } state_t;

   function automatic logic [DATA_BYTE_WD-1:0] keep_msb(
      input logic [CNT_WD-1:0] cnt
   );
      logic [DATA_BYTE_WD-1:0] k;
      for (int i = 0; i < DATA_BYTE_WD; i++)
         k[DATA_BYTE_WD-1-i] = (i < int'(cnt));
      return k;
   endfunction

   function automatic logic [DATA_BYTE_WD-1:0] keep_lsb(
      input logic [CNT_WD-1:0] cnt
   );
      logic [DATA_BYTE_WD-1:0] k;
      for (int i = 0; i < DATA_BYTE_WD; i++)
         k[i] = (i < int'(cnt));
      return k;
   endfunction

endpackage

// File: rtl/axi_stream_keep_cnt.sv
// MSB-aligned contiguous keep mask to byte count.
// Contiguity lets a plain popcount stand in for a leading-ones scan.
module axi_stream_keep_cnt #(
   parameter int DATA_BYTE_WD = axi_stream_pkg::DATA_BYTE_WD,
   parameter int CNT_WD       = $clog2(DATA_BYTE_WD + 1)
) (
   input  logic [DATA_BYTE_WD-1:0] keep,
   output logic [CNT_WD-1:0]       cnt
);

   // count set keep bits
   always_comb begin
      cnt = '0;
      for (int i = 0; i < DATA_BYTE_WD; i++)
         cnt = cnt + CNT_WD'(keep[i]);
   end

endmodule

// File: rtl/axi_stream_extract_header.sv
// Splits a prepended header off an AXI-Stream packet and realigns the
// remaining payload onto MSB-first beats through one registered stage.
module axi_stream_extract_header #(
   parameter int DATA_WD      = axi_stream_pkg::DATA_WD,
   parameter int DATA_BYTE_WD = DATA_WD / 8,
   parameter int CNT_WD       = $clog2(DATA_BYTE_WD + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    valid_in,
   input  logic [DATA_WD-1:0]      data_in,
   input  logic [DATA_BYTE_WD-1:0] keep_in,
   input  logic                    last_in,
   output logic                    ready_in,
   input  logic [CNT_WD-1:0]       hdr_len_in,
   output logic                    valid_hdr,
   output logic [DATA_WD-1:0]      header_out,
   output logic [DATA_BYTE_WD-1:0] keep_hdr,
   input  logic                    ready_hdr,
   output logic                    valid_out,
   output logic [DATA_WD-1:0]      data_out,
   output logic [DATA_BYTE_WD-1:0] keep_out,
   output logic                    last_out,
   input  logic                    ready_out
);
   import axi_stream_pkg::*;

   localparam logic [CNT_WD-1:0] FULL = CNT_WD'(DATA_BYTE_WD);
   localparam logic [CNT_WD:0]   FULLX = (CNT_WD+1)'(DATA_BYTE_WD);

   state_t                  state, state_d;
   logic [DATA_WD-1:0]      res_data, res_data_d;
   logic [CNT_WD-1:0]       res_cnt, res_cnt_d;
   logic                    valid_out_d, last_out_d;
   logic [DATA_WD-1:0]      data_out_d;
   logic [DATA_BYTE_WD-1:0] keep_out_d;
   logic                    valid_hdr_d;
   logic [DATA_WD-1:0]      header_d;
   logic [DATA_BYTE_WD-1:0] keep_hdr_d;

   logic [CNT_WD-1:0]       in_cnt, hdr_n, hdr_take;
   logic [CNT_WD:0]         sum;
   logic [DATA_WD-1:0]      data_m;
   logic                    out_free, hdr_free, in_fire;

   axi_stream_keep_cnt #(
      .DATA_BYTE_WD(DATA_BYTE_WD),
      .CNT_WD      (CNT_WD)
   ) u_keep_cnt (
      .keep(keep_in),
      .cnt (in_cnt)
   );

   assign out_free = !valid_out || ready_out;
   assign hdr_free = !valid_hdr || ready_hdr;
   assign ready_in = !rst && (state != FLUSH) && out_free &&
                     (state != SOP || hdr_free);
   assign in_fire  = valid_in && ready_in;
   assign hdr_n    = (int'(hdr_len_in) > DATA_BYTE_WD) ? FULL : hdr_len_in;
   assign hdr_take = (in_cnt < hdr_n) ? in_cnt : hdr_n;
   assign sum      = {1'b0, res_cnt} + {1'b0, in_cnt};

   // zero bytes outside keep so stale lanes never leak into outputs
   always_comb begin
      data_m = '0;
      for (int b = 0; b < DATA_BYTE_WD; b++)
         if (keep_in[b])
            data_m[8*b +: 8] = data_in[8*b +: 8];
   end

   // next-state, residue and output-register loads
   always_comb begin
      state_d     = state;
      res_data_d  = res_data;
      res_cnt_d   = res_cnt;
      valid_out_d = valid_out && !ready_out;
      data_out_d  = data_out;
      keep_out_d  = keep_out;
      last_out_d  = last_out;
      valid_hdr_d = valid_hdr && !ready_hdr;
      header_d    = header_out;
      keep_hdr_d  = keep_hdr;
      unique case (state)
         SOP: begin
            if (in_fire) begin
               if (hdr_n != '0) begin
                  valid_hdr_d = 1'b1;
                  header_d    = data_m >>
                     (8 * (DATA_BYTE_WD - int'(hdr_take)));
                  keep_hdr_d  = keep_lsb(hdr_take);
               end
               if (!last_in) begin
                  state_d = BODY;
                  if (hdr_n == '0) begin
                     valid_out_d = 1'b1;
                     data_out_d  = data_m;
                     keep_out_d  = keep_in;
                     last_out_d  = 1'b0;
                     res_data_d  = '0;
                     res_cnt_d   = '0;
                  end else begin
                     res_data_d = data_m << (8 * int'(hdr_n));
                     res_cnt_d  = FULL - hdr_n;
                  end
               end else if (in_cnt > hdr_n) begin
                  valid_out_d = 1'b1;
                  data_out_d  = data_m << (8 * int'(hdr_n));
                  keep_out_d  = keep_msb(in_cnt - hdr_n);
                  last_out_d  = 1'b1;
               end
            end
         end
         BODY: begin
            if (in_fire) begin
               valid_out_d = 1'b1;
               data_out_d  = res_data | (data_m >> (8 * int'(res_cnt)));
               res_data_d  = data_m <<
                  (8 * (DATA_BYTE_WD - int'(res_cnt)));
               if (!last_in) begin
                  keep_out_d = keep_msb(FULL);
                  last_out_d = 1'b0;
               end else if (sum <= FULLX) begin
                  keep_out_d = keep_msb(CNT_WD'(sum));
                  last_out_d = 1'b1;
                  res_data_d = '0;
                  state_d    = SOP;
               end else begin
                  keep_out_d = keep_msb(FULL);
                  last_out_d = 1'b0;
                  res_cnt_d  = CNT_WD'(sum - FULLX);
                  state_d    = FLUSH;
               end
            end
         end
         FLUSH: begin
            if (out_free) begin
               valid_out_d = 1'b1;
               data_out_d  = res_data;
               keep_out_d  = keep_msb(res_cnt);
               last_out_d  = 1'b1;
               res_data_d  = '0;
               state_d     = SOP;
            end
         end
         default: state_d = SOP;
      endcase
   end

   // register state, residue and both output channels
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= SOP;
         res_data   <= '0;
         res_cnt    <= '0;
         valid_out  <= 1'b0;
         data_out   <= '0;
         keep_out   <= '0;
         last_out   <= 1'b0;
         valid_hdr  <= 1'b0;
         header_out <= '0;
         keep_hdr   <= '0;
      end else begin
         state      <= state_d;
         res_data   <= res_data_d;
         res_cnt    <= res_cnt_d;
         valid_out  <= valid_out_d;
         data_out   <= data_out_d;
         keep_out   <= keep_out_d;
         last_out   <= last_out_d;
         valid_hdr  <= valid_hdr_d;
         header_out <= header_d;
         keep_hdr   <= keep_hdr_d;
      end
   end

endmodule

// File: tb/tb_axi_stream_extract_header.sv
// Randomized scoreboard bench for axi_stream_extract_header.
// Packets are modelled as byte lists; expected beats come from byte slicing.
module tb_axi_stream_extract_header;

   localparam int W  = 4;
   localparam int DW = 32;
   localparam int CW = 3;

   typedef struct packed {
      logic [DW-1:0] d;
      logic [W-1:0]  k;
      logic          l;
   } pay_t;

   typedef struct packed {
      logic [DW-1:0] d;
      logic [W-1:0]  k;
   } hdr_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          valid_in;
   logic [DW-1:0] data_in;
   logic [W-1:0]  keep_in;
   logic          last_in;
   logic          ready_in;
   logic [CW-1:0] hdr_len_in;
   logic          valid_hdr;
   logic [DW-1:0] header_out;
   logic [W-1:0]  keep_hdr;
   logic          ready_hdr;
   logic          valid_out;
   logic [DW-1:0] data_out;
   logic [W-1:0]  keep_out;
   logic          last_out;
   logic          ready_out;

   axi_stream_extract_header dut (
      .clk       (clk),
      .rst       (rst),
      .valid_in  (valid_in),
      .data_in   (data_in),
      .keep_in   (keep_in),
      .last_in   (last_in),
      .ready_in  (ready_in),
      .hdr_len_in(hdr_len_in),
      .valid_hdr (valid_hdr),
      .header_out(header_out),
      .keep_hdr  (keep_hdr),
      .ready_hdr (ready_hdr),
      .valid_out (valid_out),
      .data_out  (data_out),
      .keep_out  (keep_out),
      .last_out  (last_out),
      .ready_out (ready_out)
   );

   always #5 clk = ~clk;

   int   checks = 0;
   int   passes = 0;
   int   cyc = 0;
   int   hdr_block_until = 0;
   bit   rnd_out = 0;
   bit   rnd_hdr = 0;
   bit   mon_off = 0;
   bit   exp_flush;
   logic [7:0] pkt_q[$];
   pay_t pay_q[$];
   hdr_t hdr_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input bit ok, input string name,
                      input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (ok) passes++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // sink ready generators
   initial begin
      ready_out = 1'b1;
      ready_hdr = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         ready_out = rnd_out ? ($urandom_range(0, 1) == 1) : 1'b1;
         if (cyc < hdr_block_until) ready_hdr = 1'b0;
         else ready_hdr = rnd_hdr ? ($urandom_range(0, 9) < 7) : 1'b1;
      end
   end

   // scoreboard monitor for both output channels
   initial begin
      pay_t pe;
      hdr_t he;
      forever begin
         @(negedge clk);
         if (!rst && !mon_off) begin
            if (valid_out && ready_out) begin
               if (pay_q.size() == 0)
                  chk(0, "payload_extra", 64'(data_out), 64'(0));
               else begin
                  pe = pay_q.pop_front();
                  chk({data_out, keep_out, last_out} == pe, "payload",
                      64'({data_out, keep_out, last_out}), 64'(pe));
               end
            end
            if (valid_hdr && ready_hdr) begin
               if (hdr_q.size() == 0)
                  chk(0, "header_extra", 64'(header_out), 64'(0));
               else begin
                  he = hdr_q.pop_front();
                  chk({header_out, keep_hdr} == he, "header",
                      64'({header_out, keep_hdr}), 64'(he));
               end
            end
         end
      end
   end

   // reference model: slice packet bytes into header and payload beats
   task automatic push_expect(input int n);
      int   nn, tot, h, beats, p;
      hdr_t he;
      pay_t pe;
      nn  = (n > W) ? W : n;
      tot = pkt_q.size();
      h   = (nn < tot) ? nn : tot;
      if (nn > 0) begin
         he.d = '0;
         for (int i = 0; i < h; i++) he.d = (he.d << 8) | DW'(pkt_q[i]);
         he.k = W'((1 << h) - 1);
         hdr_q.push_back(he);
      end
      for (int s = h; s < tot; s += W) begin
         pe.d = '0;
         pe.k = '0;
         for (int j = 0; j < W; j++)
            if (s + j < tot) begin
               pe.d[8*(W-1-j) +: 8] = pkt_q[s+j];
               pe.k[W-1-j] = 1'b1;
            end
         pe.l = (s + W >= tot);
         pay_q.push_back(pe);
      end
      p = tot - h;
      beats = (tot + W - 1) / W;
      exp_flush = (nn > 0) && (beats > 1) && ((p + W - 1) / W > beats - 1);
   endtask

   task automatic send_pkt(input int n, input bit gaps, input int stop_after);
      int tot, beats, t;
      bit fl, acc;
      tot = pkt_q.size();
      beats = (tot + W - 1) / W;
      fl = 0;
      if (stop_after < 0) begin
         push_expect(n);
         fl = exp_flush;
      end
      for (int k = 0; k < beats; k++) begin
         if (stop_after >= 0 && k == stop_after) begin
            valid_in = 1'b0;
            return;
         end
         if (gaps && $urandom_range(0, 3) == 0) begin
            valid_in = 1'b0;
            @(posedge clk);
            #1;
         end
         valid_in   = 1'b1;
         hdr_len_in = (k == 0) ? CW'(n) : CW'($urandom);
         data_in    = $urandom;
         keep_in    = '0;
         last_in    = (k == beats - 1);
         for (int j = 0; j < W; j++)
            if (k * W + j < tot) begin
               data_in[8*(W-1-j) +: 8] = pkt_q[k*W+j];
               keep_in[W-1-j] = 1'b1;
            end
         acc = 0;
         t = 0;
         while (!acc) begin
            @(negedge clk);
            if (k == 0 && valid_hdr && !ready_hdr)
               chk(ready_in == 1'b0, "sop_hold_ready",
                   64'(ready_in), 64'(0));
            acc = ready_in;
            @(posedge clk);
            #1;
            t++;
            if (!acc && t > 300) begin
               chk(0, "input_timeout", 64'(t), 64'(300));
               valid_in = 1'b0;
               return;
            end
         end
      end
      valid_in = 1'b0;
      if (fl) begin
         @(negedge clk);
         chk(ready_in == 1'b0, "flush_ready", 64'(ready_in), 64'(0));
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_word(input logic [31:0] w, input int nb);
      for (int i = 0; i < nb; i++) pkt_q.push_back(w[31-8*i -: 8]);
   endtask

   task automatic drain();
      int t = 0;
      while ((pay_q.size() != 0 || hdr_q.size() != 0) && t < 400) begin
         @(posedge clk);
         #1;
         t++;
      end
      chk(pay_q.size() == 0 && hdr_q.size() == 0, "drain",
          64'(pay_q.size() + hdr_q.size()), 64'(0));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      valid_in = 1'b1;
      data_in = '0;
      keep_in = '1;
      last_in = 1'b0;
      hdr_len_in = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk(ready_in == 1'b0, "rst_ready_in", 64'(ready_in), 64'(0));
      chk(valid_out == 1'b0, "rst_valid_out", 64'(valid_out), 64'(0));
      chk(valid_hdr == 1'b0, "rst_valid_hdr", 64'(valid_hdr), 64'(0));
      chk(last_out == 1'b0, "rst_last_out", 64'(last_out), 64'(0));
      chk({data_out, keep_out} == '0, "rst_data_out",
          64'({data_out, keep_out}), 64'(0));
      chk({header_out, keep_hdr} == '0, "rst_header",
          64'({header_out, keep_hdr}), 64'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      valid_in = 1'b0;

      pkt_q = {};
      push_word(32'hAABBCCDD, 4);
      push_word(32'h11223344, 4);
      push_word(32'h55667788, 1);
      send_pkt(3, 0, -1);
      drain();

      pkt_q = {};
      push_word(32'hAABBCCDD, 4);
      push_word(32'h11223344, 3);
      send_pkt(1, 0, -1);
      drain();

      pkt_q = {};
      push_word(32'h01020304, 4);
      push_word(32'h05060708, 4);
      push_word(32'h090A0B0C, 4);
      send_pkt(0, 0, -1);
      drain();

      pkt_q = {};
      push_word(32'hCAFEBABE, 4);
      send_pkt(4, 0, -1);
      drain();

      rnd_out = 1;
      hdr_block_until = cyc + 10;
      pkt_q = {};
      for (int i = 0; i < 11; i++) pkt_q.push_back(8'($urandom));
      send_pkt(2, 0, -1);
      pkt_q = {};
      for (int i = 0; i < 9; i++) pkt_q.push_back(8'($urandom));
      send_pkt(2, 0, -1);
      drain();
      rnd_out = 0;

      mon_off = 1;
      pkt_q = {};
      for (int i = 0; i < 16; i++) pkt_q.push_back(8'($urandom));
      send_pkt(2, 0, 2);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk(valid_out == 1'b0, "midrst_valid_out", 64'(valid_out), 64'(0));
      chk(valid_hdr == 1'b0, "midrst_valid_hdr", 64'(valid_hdr), 64'(0));
      pay_q = {};
      hdr_q = {};
      mon_off = 0;
      pkt_q = {};
      for (int i = 0; i < 10; i++) pkt_q.push_back(8'($urandom));
      send_pkt(2, 0, -1);
      drain();

      rnd_out = 1;
      rnd_hdr = 1;
      for (int p = 0; p < 60; p++) begin
         pkt_q = {};
         for (int i = 0; i < $urandom_range(1, 14); i++)
            pkt_q.push_back(8'($urandom));
         send_pkt($urandom_range(0, 7), 1, -1);
      end
      drain();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/axi_stream_extract_header.md
Name: axi_stream_extract_header

Overview:
Downstream counterpart of axi_stream_insert_header. It takes an AXI-Stream packet whose first hdr_len_in bytes are a prepended header. The header bytes go out on a separate header channel. The remaining payload is realigned onto MSB-first beats with byte-exact keep and last. A single registered output stage gives full-throughput streaming with backpressure on all channels.

Parameters:
DATA_WD, 32, data width in bits (multiple of 8)
DATA_BYTE_WD, DATA_WD/8, bytes per beat
CNT_WD, $clog2(DATA_BYTE_WD+1), width of byte-count fields

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, synchronous, active-high
valid_in  in  1  input beat valid
data_in  in  DATA_WD  input data; byte [DATA_WD-1 -: 8] is first on the wire
keep_in  in  DATA_BYTE_WD  MSB-aligned contiguous keep (1111/1110/1100/1000 for 32b)
last_in  in  1  last beat of packet
ready_in  out  1  input ready
hdr_len_in  in  CNT_WD  header byte count 0..DATA_BYTE_WD, sampled on first-beat handshake
valid_hdr  out  1  extracted header valid
header_out  out  DATA_WD  header, LSB-aligned; first-received byte is most significant valid byte
keep_hdr  out  DATA_BYTE_WD  LSB-aligned keep of header (e.g. 0111 = 3 bytes)
ready_hdr  in  1  header sink ready
valid_out  out  1  payload beat valid
data_out  out  DATA_WD  payload, MSB-aligned
keep_out  out  DATA_BYTE_WD  MSB-aligned contiguous keep
last_out  out  1  last payload beat
ready_out  in  1  payload sink ready

Behaviour:
- Reset (rst=1 at clk edge): valid_out=0, valid_hdr=0, last_out=0, data_out=0, keep_out=0, header_out=0, keep_hdr=0, residue count r=0, state=SOP. ready_in is combinational and is 0 while rst=1.
- Handshake: a transfer occurs when valid && ready at a rising edge. Outputs are held stable while valid && !ready. keep_in must be all-ones when last_in=0; other values are a protocol error with undefined output.
- States: SOP (awaiting first beat), BODY, FLUSH.
- N = min(hdr_len_in, DATA_BYTE_WD), latched on the SOP handshake. Steady residue r = (DATA_BYTE_WD - N) mod DATA_BYTE_WD.
- SOP beat accepted, c = valid bytes:
  - Header gets the top min(N,c) bytes. valid_hdr is set and keep_hdr gets min(N,c) LSB ones.
  - If N=0, no header beat is emitted.
  - The remaining c-N bytes are handled as follows:
    - If N=0, they go directly to the output register.
    - Otherwise they go to the residue register, left-aligned.
  - Next state: BODY if !last_in. If last_in, the leftover bytes are emitted as a last_out beat, or nothing is emitted if c<=N. State then returns to SOP.
- BODY beat accepted (c bytes): output = r residue bytes followed by the top DATA_BYTE_WD-r incoming bytes. The bottom r incoming bytes become the new residue.
  - On last_in with r+c <= DATA_BYTE_WD: one beat is emitted with keep = r+c ones, last_out=1, and state goes to SOP.
  - On last_in with r+c > DATA_BYTE_WD: a full beat is emitted with last_out=0, residue becomes r+c-DATA_BYTE_WD, and state goes to FLUSH.
- FLUSH: ready_in=0. The residue beat is emitted with last_out=1 once the output register frees, then state goes to SOP.
- Latency: an output beat is valid the cycle after the input edge that completes it.
- Throughput: one beat per cycle at BODY when ready_out=1. There is one extra cycle per packet only on FLUSH.
- Ready conditions:
  - In BODY: ready_in = (!valid_out || ready_out).
  - In SOP: ready_in additionally requires (!valid_hdr || ready_hdr), and (!valid_out || ready_out) still applies.
  - A new packet cannot start while the previous header is still pending.
- valid_hdr clears on the header handshake. It is independent of payload flow, so a payload may drain while its header is stalled.
- Reset mid-packet discards the residue, the header and any partial packet. The first beat after reset is treated as SOP.

Decomposition:
- Shared package axi_stream_pkg holds:
  - DATA_WD/DATA_BYTE_WD defaults
  - the state enum (SOP/BODY/FLUSH)
  - functions keep_msb(cnt) and keep_lsb(cnt) mapping a count to a keep mask
- One sub-module, axi_stream_keep_cnt: combinational conversion of an MSB-aligned keep to a byte count (CNT_WD). It is reused by the insert-header block.

Test Plan:
- N=3, beats 0xAABBCCDD/1111, 0x11223344/1111, 0x55667788/1000+last, all readies 1 -> header 0x00AABBCC keep 0111. Payload 0xDD112233/1111, then 0x44550000/1100 last.
- N=1, beats 0xAABBCCDD/1111, 0x11223344/1110+last -> header 0x000000AA/0001. Payload 0xBBCCDD11/1111, then FLUSH beat 0x22330000/1100 last. ready_in=0 during the FLUSH cycle.
- N=0, 3-beat packet -> no valid_hdr; payload identical to input, delayed one cycle, last preserved.
- N=4, single beat 0xCAFEBABE/1111+last -> header 0xCAFEBABE/1111; no payload beat emitted.
- Backpressure: N=2 with ready_out random 50% and ready_hdr held 0 for 10 cycles -> payload data unchanged and no beat lost or duplicated. Next packet's first beat is not accepted until the header handshake completes.
- Reset asserted for 1 cycle mid-BODY -> all valids 0 next cycle. A following packet with N=2 extracts correctly from SOP.
